// File: rtl/gate_model_bist.sv
// gate_model_bist: built-in self-test harness for GateModel netlists.
// An LFSR drives the DUT inputs and a MISR compacts the DUT outputs. The final
// signature is compared against a golden value.
// Optional feature: define GATE_BIST_SEED_LOAD_EN to add the seed_in/golden_in
// ports, which are sampled on the start edge. In that build the SEED and GOLDEN
// parameters are ignored.
module gate_model_bist #(
  parameter int unsigned      N_IN      = 22,
  parameter int unsigned      N_OUT     = 10,
  parameter int unsigned      N_PAT     = 256,
  parameter int unsigned      LAT       = 0,
  parameter logic [N_IN-1:0]  LFSR_TAPS = 22'h300000,
  parameter logic [N_OUT-1:0] MISR_TAPS = 10'h240,
  parameter logic [N_IN-1:0]  SEED      = {{(N_IN-1){1'b0}}, 1'b1},
  parameter logic [N_OUT-1:0] GOLDEN    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_BIST_SEED_LOAD_EN
  input  logic [N_IN-1:0]  seed_in,
  input  logic [N_OUT-1:0] golden_in,
`endif
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  localparam int unsigned     CNT_W    = $clog2(N_PAT + LAT + 1);
  localparam int              LAT_I    = int'(LAT);
  // Counter value of the last RUN cycle and of the last busy cycle.
  localparam int              RUN_LAST = int'(N_PAT) - 1;
  localparam int              RUN_END  = int'(N_PAT + LAT) - 1;
  localparam logic [N_IN-1:0] ONE_IN   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] SEED_EFF = (SEED == '0) ? ONE_IN : SEED;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    lfsr_q, lfsr_d;
  logic [N_OUT-1:0]   misr_q, misr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [N_IN-1:0]    lfsr_step;
  logic [N_OUT-1:0]   misr_step;
  logic [N_IN-1:0]    start_seed;
  logic [N_OUT-1:0]   golden_cur;
  logic [N_IN-1:0]    rst_seed;
  int                 cnt_i;

`ifdef GATE_BIST_SEED_LOAD_EN
  logic [N_OUT-1:0]   golden_q, golden_d;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign start_seed = (seed_in == '0) ? ONE_IN : seed_in;
  assign golden_cur = golden_q;
  assign rst_seed   = ONE_IN;

  // Golden value captured with the seed on the start edge.
  always_comb begin
    golden_d = golden_q;
    if ((state_q == StIdle || state_q == StDone) && start) begin
      golden_d = golden_in;
    end
  end

  // Golden value register.
  always_ff @(posedge clk) begin
    if (rst) begin
      golden_q <= '0;
    end else begin
      golden_q <= golden_d;
    end
  end
`else
  assign start_seed = SEED_EFF;
  assign golden_cur = GOLDEN;
  assign rst_seed   = SEED_EFF;
`endif

  assign lfsr_step = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign misr_step = {misr_q[N_OUT-2:0], ^(misr_q & MISR_TAPS)} ^ dut_out;
  assign cnt_i     = int'(cnt_q);

  // Next-state logic: sequencing, pattern generation and compaction.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          lfsr_d  = start_seed;
          misr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StRun, StFlush: begin
        // The LFSR only advances while patterns are being applied.
        if (state_q == StRun) begin
          lfsr_d = lfsr_step;
        end
        // Compaction starts LAT cycles after RUN entry so that each response
        // is absorbed on the cycle it appears at the DUT output.
        if (cnt_i >= LAT_I) begin
          misr_d = misr_step;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_i == RUN_END) begin
          state_d = StDone;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_d == golden_cur);
        end else if (cnt_i == RUN_LAST) begin
          state_d = StFlush;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= rst_seed;
      misr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in    = lfsr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule
